mem_arbiter: RTL and testbench

Two-port arbiter that shares the single simulation memory device between the instruction-fetch (IF) and load/store (LS) requesters. It accepts at most one request at a time, forwards it to the memory device for exactly one cycle, captures the device's registered response, and returns it to the originating port. The block sits between the core pipeline and the memory device and is the device's only master.

---
 rtl/mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory device between the instruction-fetch (IF)
// and load/store (LS) requesters. Only one request is in flight at a time. Each
// request is forwarded to the device for exactly one cycle, and the device's
// registered response is returned to the port that made the request.
//
// Configuration macro: MEM_ARB_RR_EN
//   undefined (default): fixed priority, LS wins over IF.
//   defined            : round-robin arbitration using a 1-bit last-granted pointer.

`ifndef MEM_ADDR_W_DEFINED
`define MEM_ADDR_W_DEFINED
`define ADDR_W 32
`define WORD_W 32
`define MEM_COUNT_W 2
`define MEM_CODE_W 3
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`define MEM_CODE_READ 3'd1
`define MEM_CODE_WRITE 3'd2
`define MEM_CODE_MISALIGNED 3'd3
`define MEM_CODE_OUT_OF_BOUNDS 3'd4
`define MEM_CODE_INVALID 3'd5
`endif

module mem_arbiter #(
  parameter logic [`MEM_COUNT_W-1:0] MEM_ARB_IDLE_COUNT = `MEM_COUNT_NONE
) (
  input  logic                    clk,
  input  logic                    aresetn,
  // instruction-fetch port
  input  logic                    i_if_req_valid,
  input  logic [`ADDR_W-1:0]      i_if_req_addr,
  input  logic [`WORD_W-1:0]      i_if_req_wr_data,
  input  logic                    i_if_req_wr_en,
  input  logic [`MEM_COUNT_W-1:0] i_if_req_count,
  output logic                    o_if_req_ready,
  output logic                    o_if_res_valid,
  output logic [`WORD_W-1:0]      o_if_res_rd_data,
  output logic [`MEM_CODE_W-1:0]  o_if_res_code,
  // load/store port
  input  logic                    i_ls_req_valid,
  input  logic [`ADDR_W-1:0]      i_ls_req_addr,
  input  logic [`WORD_W-1:0]      i_ls_req_wr_data,
  input  logic                    i_ls_req_wr_en,
  input  logic [`MEM_COUNT_W-1:0] i_ls_req_count,
  output logic                    o_ls_req_ready,
  output logic                    o_ls_res_valid,
  output logic [`WORD_W-1:0]      o_ls_res_rd_data,
  output logic [`MEM_CODE_W-1:0]  o_ls_res_code,
  // memory device
  output logic [`ADDR_W-1:0]      o_mem_req_addr,
  output logic [`WORD_W-1:0]      o_mem_req_wr_data,
  output logic                    o_mem_req_wr_en,
  output logic [`MEM_COUNT_W-1:0] o_mem_req_count,
  input  logic [`WORD_W-1:0]      i_mem_res_rd_data,
  input  logic [`MEM_CODE_W-1:0]  i_mem_res_code,
  output logic                    o_busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e                  state_q, state_d;
  logic                    grant_ls_q, grant_ls_d;
  logic [`ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [`WORD_W-1:0]      mem_wr_data_q, mem_wr_data_d;
  logic                    mem_wr_en_q, mem_wr_en_d;
  logic [`MEM_COUNT_W-1:0] mem_count_q, mem_count_d;
  logic                    if_res_valid_q, if_res_valid_d;
  logic [`WORD_W-1:0]      if_res_rd_data_q, if_res_rd_data_d;
  logic [`MEM_CODE_W-1:0]  if_res_code_q, if_res_code_d;
  logic                    ls_res_valid_q, ls_res_valid_d;
  logic [`WORD_W-1:0]      ls_res_rd_data_q, ls_res_rd_data_d;
  logic [`MEM_CODE_W-1:0]  ls_res_code_q, ls_res_code_d;

  logic ls_pri;
  logic pick_ls;
  logic if_ready;
  logic ls_ready;

`ifdef MEM_ARB_RR_EN
  // 1 when LS was granted last; resets to IF so the first conflict goes to LS
  logic last_ls_q, last_ls_d;
  assign ls_pri = ~last_ls_q;
`else
  assign ls_pri = 1'b1;
`endif

  // Grant selection: a lone valid port always wins, ls_pri breaks conflicts
  always_comb begin
    pick_ls  = i_ls_req_valid & (~i_if_req_valid | ls_pri);
    ls_ready = (state_q == StIdle) & pick_ls;
    if_ready = (state_q == StIdle) & i_if_req_valid & ~pick_ls;
  end

  // Next-state and registered-output logic for the IDLE/ISSUE/CAPTURE sequence
  always_comb begin
    state_d          = state_q;
    grant_ls_d       = grant_ls_q;
    mem_addr_d       = mem_addr_q;
    mem_wr_data_d    = mem_wr_data_q;
    mem_wr_en_d      = mem_wr_en_q;
    mem_count_d      = mem_count_q;
    if_res_valid_d   = 1'b0;
    if_res_rd_data_d = if_res_rd_data_q;
    if_res_code_d    = if_res_code_q;
    ls_res_valid_d   = 1'b0;
    ls_res_rd_data_d = ls_res_rd_data_q;
    ls_res_code_d    = ls_res_code_q;
`ifdef MEM_ARB_RR_EN
    last_ls_d        = last_ls_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (if_ready || ls_ready) begin
          state_d    = StIssue;
          grant_ls_d = ls_ready;
`ifdef MEM_ARB_RR_EN
          last_ls_d  = ls_ready;
`endif
          if (ls_ready) begin
            mem_addr_d    = i_ls_req_addr;
            mem_wr_data_d = i_ls_req_wr_data;
            mem_wr_en_d   = i_ls_req_wr_en;
            mem_count_d   = i_ls_req_count;
          end else begin
            mem_addr_d    = i_if_req_addr;
            mem_wr_data_d = i_if_req_wr_data;
            mem_wr_en_d   = i_if_req_wr_en;
            mem_count_d   = i_if_req_count;
          end
        end
      end
      StIssue: begin
        // Request is presented for exactly one cycle, then the bus goes idle
        state_d       = StCapture;
        mem_addr_d    = '0;
        mem_wr_data_d = '0;
        mem_wr_en_d   = 1'b0;
        mem_count_d   = MEM_ARB_IDLE_COUNT;
      end
      StCapture: begin
        state_d = StIdle;
        if (grant_ls_q) begin
          ls_res_valid_d   = 1'b1;
          ls_res_rd_data_d = i_mem_res_rd_data;
          ls_res_code_d    = i_mem_res_code;
        end else begin
          if_res_valid_d   = 1'b1;
          if_res_rd_data_d = i_mem_res_rd_data;
          if_res_code_d    = i_mem_res_code;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any transaction without a response
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q          <= StIdle;
      grant_ls_q       <= 1'b0;
      mem_addr_q       <= '0;
      mem_wr_data_q    <= '0;
      mem_wr_en_q      <= 1'b0;
      mem_count_q      <= MEM_ARB_IDLE_COUNT;
      if_res_valid_q   <= 1'b0;
      if_res_rd_data_q <= '0;
      if_res_code_q    <= '0;
      ls_res_valid_q   <= 1'b0;
      ls_res_rd_data_q <= '0;
      ls_res_code_q    <= '0;
`ifdef MEM_ARB_RR_EN
      last_ls_q        <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      grant_ls_q       <= grant_ls_d;
      mem_addr_q       <= mem_addr_d;
      mem_wr_data_q    <= mem_wr_data_d;
      mem_wr_en_q      <= mem_wr_en_d;
      mem_count_q      <= mem_count_d;
      if_res_valid_q   <= if_res_valid_d;
      if_res_rd_data_q <= if_res_rd_data_d;
      if_res_code_q    <= if_res_code_d;
      ls_res_valid_q   <= ls_res_valid_d;
      ls_res_rd_data_q <= ls_res_rd_data_d;
      ls_res_code_q    <= ls_res_code_d;
`ifdef MEM_ARB_RR_EN
      last_ls_q        <= last_ls_d;
`endif
    end
  end

  assign o_if_req_ready    = if_ready;
  assign o_ls_req_ready    = ls_ready;
  assign o_if_res_valid    = if_res_valid_q;
  assign o_if_res_rd_data  = if_res_rd_data_q;
  assign o_if_res_code     = if_res_code_q;
  assign o_ls_res_valid    = ls_res_valid_q;
  assign o_ls_res_rd_data  = ls_res_rd_data_q;
  assign o_ls_res_code     = ls_res_code_q;
  assign o_mem_req_addr    = mem_addr_q;
  assign o_mem_req_wr_data = mem_wr_data_q;
  assign o_mem_req_wr_en   = mem_wr_en_q;
  assign o_mem_req_count   = mem_count_q;
  assign o_busy            = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven requests through a behavioural memory device, with a
// scoreboard of expected responses, plus hand-written conflict and reset sequences.

`ifndef MEM_ADDR_W_DEFINED
`define MEM_ADDR_W_DEFINED
`define ADDR_W 32
`define WORD_W 32
`define MEM_COUNT_W 2
`define MEM_CODE_W 3
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`define MEM_CODE_READ 3'd1
`define MEM_CODE_WRITE 3'd2
`define MEM_CODE_MISALIGNED 3'd3
`define MEM_CODE_OUT_OF_BOUNDS 3'd4
`define MEM_CODE_INVALID 3'd5
`endif

module tb_mem_arbiter;

  localparam int WordCount = 16;
  localparam int MemBytes  = WordCount * 4;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        if_valid = 1'b0, ls_valid = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, if_wdata = '0, ls_wdata = '0;
  logic        if_wr_en = 1'b0, ls_wr_en = 1'b0;
  logic [1:0]  if_count = '0, ls_count = '0;
  logic        if_ready, ls_ready, if_res_valid, ls_res_valid;
  logic [31:0] if_res_data, ls_res_data;
  logic [2:0]  if_res_code, ls_res_code;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wr_en;
  logic [1:0]  mem_count;
  logic [31:0] dev_data = '0;
  logic [2:0]  dev_code = '0;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .i_if_req_valid    (if_valid),
    .i_if_req_addr     (if_addr),
    .i_if_req_wr_data  (if_wdata),
    .i_if_req_wr_en    (if_wr_en),
    .i_if_req_count    (if_count),
    .o_if_req_ready    (if_ready),
    .o_if_res_valid    (if_res_valid),
    .o_if_res_rd_data  (if_res_data),
    .o_if_res_code     (if_res_code),
    .i_ls_req_valid    (ls_valid),
    .i_ls_req_addr     (ls_addr),
    .i_ls_req_wr_data  (ls_wdata),
    .i_ls_req_wr_en    (ls_wr_en),
    .i_ls_req_count    (ls_count),
    .o_ls_req_ready    (ls_ready),
    .o_ls_res_valid    (ls_res_valid),
    .o_ls_res_rd_data  (ls_res_data),
    .o_ls_res_code     (ls_res_code),
    .o_mem_req_addr    (mem_addr),
    .o_mem_req_wr_data (mem_wdata),
    .o_mem_req_wr_en   (mem_wr_en),
    .o_mem_req_count   (mem_count),
    .i_mem_res_rd_data (dev_data),
    .i_mem_res_code    (dev_code),
    .o_busy            (busy)
  );

  // Behavioural memory device: registers a response to whatever request is on the bus
  logic [7:0] mem [MemBytes];

  function automatic int size_of(input logic [1:0] c);
    if (c == `MEM_COUNT_BYTE) return 1;
    if (c == `MEM_COUNT_HALF) return 2;
    return 4;
  endfunction

  always @(posedge clk) begin
    int sz;
    logic [31:0] rd;
    sz = size_of(mem_count);
    rd = '0;
    if (mem_count == `MEM_COUNT_NONE) begin
      dev_code <= `MEM_CODE_INVALID;
      dev_data <= '0;
    end else if ((mem_addr % sz) != 0) begin
      dev_code <= `MEM_CODE_MISALIGNED;
      dev_data <= '0;
    end else if ({32'd0, mem_addr} + 64'(sz) > 64'(MemBytes)) begin
      dev_code <= `MEM_CODE_OUT_OF_BOUNDS;
      dev_data <= '0;
    end else if (mem_wr_en) begin
      for (int k = 0; k < sz; k++) mem[int'(mem_addr) + k] <= mem_wdata[8*k +: 8];
      dev_code <= `MEM_CODE_WRITE;
      dev_data <= '0;
    end else begin
      for (int k = 0; k < sz; k++) rd[8*k +: 8] = mem[int'(mem_addr) + k];
      dev_code <= `MEM_CODE_READ;
      dev_data <= rd;
    end
  end

  typedef struct {
    logic        ls;
    logic [31:0] addr;
    logic        wr_en;
    logic [31:0] wdata;
    logic [1:0]  count;
    logic [31:0] exp_data;
    logic [2:0]  exp_code;
  } vec_t;

  typedef struct {
    logic        ls;
    logic [31:0] data;
    logic [2:0]  code;
    int          hs_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] if_last_data = '0, ls_last_data = '0;
  logic [2:0]  if_last_code = '0, ls_last_code = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare any response pulse against the scoreboard head
  task automatic monitor();
    exp_t e;
    if (if_res_valid && ls_res_valid) begin
      check("dual_res_valid", 32'd1, 32'd0);
    end else if (if_res_valid || ls_res_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_port_is_ls", {31'd0, ls_res_valid}, {31'd0, e.ls});
        // handshake edge E0 -> response sampled after edge E2
        check("res_latency", cyc - e.hs_cyc, 32'd2);
        if (ls_res_valid) begin
          check("ls_res_data", ls_res_data, e.data);
          check("ls_res_code", {29'd0, ls_res_code}, {29'd0, e.code});
          check("if_res_data_held", if_res_data, if_last_data);
          check("if_res_code_held", {29'd0, if_res_code}, {29'd0, if_last_code});
          ls_last_data = e.data;
          ls_last_code = e.code;
        end else begin
          check("if_res_data", if_res_data, e.data);
          check("if_res_code", {29'd0, if_res_code}, {29'd0, e.code});
          check("ls_res_data_held", ls_res_data, ls_last_data);
          check("ls_res_code_held", {29'd0, ls_res_code}, {29'd0, ls_last_code});
          if_last_data = e.data;
          if_last_code = e.code;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic push_exp(input logic ls, input logic [31:0] d, input logic [2:0] c);
    exp_t e;
    e.ls = ls;
    e.data = d;
    e.code = c;
    e.hs_cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_readies"}, {30'd0, if_ready, ls_ready}, 32'd0);
    check({tag, "_res_valids"}, {30'd0, if_res_valid, ls_res_valid}, 32'd0);
    check({tag, "_if_res"}, if_res_data | {29'd0, if_res_code}, 32'd0);
    check({tag, "_ls_res"}, ls_res_data | {29'd0, ls_res_code}, 32'd0);
    check({tag, "_mem_req"}, mem_addr | mem_wdata | {31'd0, mem_wr_en}, 32'd0);
    check({tag, "_mem_count"}, {30'd0, mem_count}, {30'd0, `MEM_COUNT_NONE});
  endtask

  // Single request on one port, held until accepted
  task automatic run_vec(input vec_t v);
    logic got;
    got = 1'b0;
    if (v.ls) begin
      ls_valid = 1'b1; ls_addr = v.addr; ls_wr_en = v.wr_en;
      ls_wdata = v.wdata; ls_count = v.count;
    end else begin
      if_valid = 1'b1; if_addr = v.addr; if_wr_en = v.wr_en;
      if_wdata = v.wdata; if_count = v.count;
    end
    for (int i = 0; i < 8 && !got; i++) begin
      #1;
      if ((v.ls && ls_ready) || (!v.ls && if_ready)) begin
        check("other_ready_low", {31'd0, v.ls ? if_ready : ls_ready}, 32'd0);
        push_exp(v.ls, v.exp_data, v.exp_code);
        got = 1'b1;
      end
      tick();
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    check("busy_after_handshake", {31'd0, busy}, {31'd0, got});
    if (got) check("mem_req_addr", mem_addr, v.addr);
    if_valid = 1'b0;
    ls_valid = 1'b0;
    drain();
  endtask

  vec_t vecs[10];
  logic exp_order[4];

  initial begin
    int   grants;
    logic g_ls;

    for (int i = 0; i < MemBytes; i++) mem[i] = 8'h00;
    {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]} = 32'hDEADBEEF;
    {mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]} = 32'h12345678;

    //        ls    addr   wr    wdata       count            exp_data      exp_code
    vecs[0] = '{1'b0, 32'h10, 1'b0, 32'h0,  `MEM_COUNT_WORD, 32'hDEADBEEF, `MEM_CODE_READ};
    vecs[1] = '{1'b1, 32'h10, 1'b1, 32'h0,  `MEM_COUNT_WORD, 32'h0,        `MEM_CODE_WRITE};
    vecs[2] = '{1'b1, 32'h13, 1'b1, 32'hA5, `MEM_COUNT_BYTE, 32'h0,        `MEM_CODE_WRITE};
    vecs[3] = '{1'b1, 32'h10, 1'b0, 32'h0,  `MEM_COUNT_WORD, 32'hA5000000, `MEM_CODE_READ};
    vecs[4] = '{1'b1, 32'h03, 1'b0, 32'h0,  `MEM_COUNT_HALF, 32'h0,        `MEM_CODE_MISALIGNED};
    vecs[5] = '{1'b1, 32'h40, 1'b0, 32'h0,  `MEM_COUNT_WORD, 32'h0,        `MEM_CODE_OUT_OF_BOUNDS};
    vecs[6] = '{1'b0, 32'h44, 1'b0, 32'h0,  `MEM_COUNT_WORD, 32'h0,        `MEM_CODE_OUT_OF_BOUNDS};
    vecs[7] = '{1'b0, 32'h10, 1'b0, 32'h0,  `MEM_COUNT_NONE, 32'h0,        `MEM_CODE_INVALID};
    vecs[8] = '{1'b0, 32'h12, 1'b0, 32'h0,  `MEM_COUNT_HALF, 32'h0000A500, `MEM_CODE_READ};
    vecs[9] = '{1'b0, 32'h20, 1'b0, 32'h0,  `MEM_COUNT_BYTE, 32'h00000078, `MEM_CODE_READ};

`ifdef MEM_ARB_RR_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    aresetn = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset while the request sits in ISSUE: aborted, no response pulse
    if_valid = 1'b1; if_addr = 32'h20; if_wr_en = 1'b0; if_count = `MEM_COUNT_WORD;
    #1;
    check("abort_if_ready", {31'd0, if_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    check("abort_in_issue_busy", {31'd0, busy}, 32'd1);
    aresetn = 1'b0;
    #1;
    check_reset_values("midreset");
    if_last_data = '0; if_last_code = '0; ls_last_data = '0; ls_last_code = '0;
    #1;
    aresetn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    run_vec('{1'b0, 32'h20, 1'b0, 32'h0, `MEM_COUNT_WORD, 32'h12345678, `MEM_CODE_READ});

    // Continuous conflict; reset first so the round-robin pointer starts at IF
    aresetn = 1'b0;
    #1;
    aresetn = 1'b1;
    if_last_data = '0; if_last_code = '0; ls_last_data = '0; ls_last_code = '0;
    if_valid = 1'b1; if_addr = 32'h20; if_wr_en = 1'b0; if_count = `MEM_COUNT_WORD;
    ls_valid = 1'b1; ls_addr = 32'h20; ls_wr_en = 1'b0; ls_count = `MEM_COUNT_WORD;
    grants = 0;
    for (int i = 0; i < 40 && grants < 4; i++) begin
      #1;
      if (if_ready || ls_ready) begin
        check("conflict_one_ready", {30'd0, if_ready, ls_ready} == 32'd3 ? 32'd1 : 32'd0, 32'd0);
        g_ls = ls_ready;
        check($sformatf("conflict_grant%0d_is_ls", grants), {31'd0, g_ls},
              {31'd0, exp_order[grants]});
        push_exp(g_ls, 32'h12345678, `MEM_CODE_READ);
        grants++;
      end
      tick();
    end
    check("conflict_grant_count", grants, 32'd4);
    if_valid = 1'b0;
    ls_valid = 1'b0;
    drain();
    for (int i = 0; i < 3; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
